// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// i2s_tx : WM8731 DAC serializer draining a show-ahead stereo FIFO (I2S master)
//          optional macro I2S_TX_LJ_EN selects left-justified format. Rev 1.0
// ============================================================================
module i2s_tx #(
  parameter int DW        = 16,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [2*DW-1:0] fifo_rd_data,
  input  logic            fifo_empty,
  output logic            fifo_rd_en,
  output logic            bclk,
  output logic            lrck,
  output logic            dacdat,
  output logic            underrun,
  output logic [15:0]     underrun_cnt
);

  localparam int c_FB    = 2 * SLOT_W;
  localparam int c_POS_W = $clog2(c_FB);
  localparam int c_HC_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(c_FB - 1);
  localparam logic [c_POS_W-1:0] c_POS_ONE  = c_POS_W'(1);
  localparam logic [c_POS_W-1:0] c_SLOT     = c_POS_W'(SLOT_W);
  localparam logic [c_HC_W-1:0]  c_HC_LAST  = c_HC_W'(BCLK_HALF - 1);
  localparam logic [c_HC_W-1:0]  c_HC_ONE   = c_HC_W'(1);
`ifdef I2S_TX_LJ_EN
  localparam logic c_LRCK_RST = 1'b0;
`else
  localparam logic c_LRCK_RST = 1'b1;
`endif

  logic [c_HC_W-1:0]  r_hc;
  logic [c_POS_W-1:0] r_pos;
  logic [c_FB-1:0]    r_shift;

  logic               w_fall;
  logic               w_load;
  logic [c_POS_W-1:0] w_pos_nxt;
  logic [c_FB-1:0]    w_word;
  logic [c_FB-1:0]    w_frame;

  assign w_fall    = (r_hc == c_HC_LAST) && bclk;
  assign w_load    = (r_pos == c_POS_LAST);
  assign w_pos_nxt = w_load ? '0 : r_pos + c_POS_ONE;

  // Each channel sits MSB-aligned in its slot, padded with zeros below.
  assign w_word  = ({{(c_FB-DW){1'b0}}, fifo_rd_data[2*DW-1:DW]} << (c_FB - DW))
                 | ({{(c_FB-DW){1'b0}}, fifo_rd_data[DW-1:0]}    << (SLOT_W - DW));
  assign w_frame = fifo_empty ? '0 : w_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc         <= '0;
      r_pos        <= c_POS_LAST;
      r_shift      <= '0;
      bclk         <= 1'b0;
      lrck         <= c_LRCK_RST;
      dacdat       <= 1'b0;
      fifo_rd_en   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (!en) begin
      r_hc       <= '0;
      r_pos      <= c_POS_LAST;
      r_shift    <= '0;
      bclk       <= 1'b0;
      lrck       <= c_LRCK_RST;
      dacdat     <= 1'b0;
      fifo_rd_en <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      underrun   <= 1'b0;
      if (r_hc == c_HC_LAST) begin
        r_hc <= '0;
        bclk <= ~bclk;
      end else begin
        r_hc <= r_hc + c_HC_ONE;
      end

      if (w_fall) begin
        r_pos <= w_pos_nxt;
`ifdef I2S_TX_LJ_EN
        lrck <= (w_pos_nxt < c_SLOT);
        if (w_load) begin
          dacdat  <= w_frame[c_FB-1];
          r_shift <= w_frame << 1;
        end else begin
          dacdat  <= r_shift[c_FB-1];
          r_shift <= r_shift << 1;
        end
`else
        // Top of the shifter lags the frame by one bit, giving the I2S delay.
        lrck    <= (w_pos_nxt >= c_SLOT);
        dacdat  <= r_shift[c_FB-1];
        r_shift <= w_load ? w_frame : (r_shift << 1);
`endif
        if (w_load) begin
          fifo_rd_en <= ~fifo_empty;
          underrun   <= fifo_empty;
          if (fifo_empty && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio serializer that drains the DAC-side async FIFO in the codec clock domain and drives the WM8731 DAC serial interface (BCLK, DACLRC, DACDAT) as bus master.
- Sits directly downstream of the async FIFO's read port; FIFO is configured show-ahead (RD_FAST=1, W=2*DW), one word = one stereo frame {left, right}.
- Pops one word per audio frame. Outputs silence and flags underrun when the FIFO is empty at frame start.

Parameters:
- DW, 16, sample width per channel in bits.
- SLOT_W, 32, BCLK periods per channel slot; must satisfy SLOT_W >= DW.
- BCLK_HALF, 2, clk cycles per BCLK half-period, >= 1. Default gives 12.288 MHz clk -> 3.072 MHz BCLK -> 48 kHz fs.

Ports:
- clk  input  1  codec master clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  run enable, synchronous to clk.
- fifo_rd_data  input  2*DW  show-ahead FIFO word, {left[2*DW-1:DW], right[DW-1:0]}.
- fifo_empty  input  1  FIFO empty.
- fifo_rd_en  output  1  pop strobe, one clk wide.
- bclk  output  1  bit clock to codec.
- lrck  output  1  DACLRC; low = left, high = right (I2S).
- dacdat  output  1  serial data, changes on BCLK falling edge.
- underrun  output  1  one-clk pulse when a frame starts with FIFO empty.
- underrun_cnt  output  16  saturating underrun counter.

Behaviour:
- Reset values: bclk=0, lrck=1, dacdat=0, fifo_rd_en=0, underrun=0, underrun_cnt=0. Internal state: hc=0, pos=2*SLOT_W-1, frame register F=0, delayed bit=0.
- hc counts 0..BCLK_HALF-1 while en=1. When hc==BCLK_HALF-1: bclk toggles and hc->0.
- A "fall event" is the clk cycle in which bclk toggles 1->0. All of the following are registered on that same edge:
  - pos advances modulo 2*SLOT_W.
  - lrck <= (new pos >= SLOT_W).
  - dacdat updates.
- Frame register F is 2*SLOT_W bits: {L, (SLOT_W-DW) zeros, R, (SLOT_W-DW) zeros}. Serialized MSB first.
- I2S one-bit delay: at frame position p, dacdat = F[p-1] (MSB-first index). At p=0, dacdat = the last bit of the previous frame (0 if SLOT_W>DW; right-channel LSB if SLOT_W==DW).
- Frame load happens on the fall event where pos wraps 2*SLOT_W-1 -> 0.
  - FIFO not empty: fifo_rd_en=1 for exactly that clk; F <= fifo_rd_data sampled in the same cycle (show-ahead).
  - FIFO empty: no pop; F <= 0; underrun=1 for that clk; underrun_cnt increments, saturating at 16'hFFFF. Next frame retries normally.
- fifo_rd_en is never asserted at any other time. At most one pop per 2*SLOT_W*2*BCLK_HALF clks.
- Timing after en rises from reset state:
  - first bclk rise at clk BCLK_HALF;
  - first fall event (first load, lrck->0) at clk 2*BCLK_HALF;
  - first left MSB on dacdat one BCLK period later.
- en deassert: next clk returns hc, bclk, pos, lrck, dacdat and F to reset values.
  - underrun_cnt is retained.
  - No pop occurs while en=0 or in the deasserting cycle.
  - Mid-frame deassert truncates the frame; the partially sent word is lost.
- Reset mid-operation: immediate return to reset values, including underrun_cnt.
- No internal sample buffering beyond F; FIFO pointer state is owned upstream.

Optional Feature:
- Macro I2S_TX_LJ_EN.
- Defined: left-justified format.
  - lrck high = left: lrck <= (pos < SLOT_W); reset value lrck=0.
  - No one-bit delay: dacdat = F[p].
  - Left MSB appears on the same fall event as the frame load.
- Undefined: standard I2S as specified above.

Test Plan (defaults: DW=16, SLOT_W=32, BCLK_HALF=2; frame = 256 clks):
- Reset then en=1, FIFO holds 32'hA5A5_3C3C.
  - bclk period 4 clks; lrck falls at clk 4; fifo_rd_en single pulse at clk 4.
  - dacdat shows 1010010110100101 on BCLK periods 1..16, then zeros.
  - lrck rises at period 32; right-channel 0011110000111100 on periods 33..48.
- 10 queued frames, FIFO kept non-empty: exactly one fifo_rd_en per 256 clks; no underrun; data bit-exact against model for all frames.
- fifo_empty=1 at a frame boundary: no fifo_rd_en; 64 BCLKs of dacdat=0; underrun pulses once; underrun_cnt=1; next frame pops normally once data is present.
- en dropped at pos=20: next clk bclk=0, lrck=1, dacdat=0. Re-enable: first load at clk 4 after en, no extra pop, underrun_cnt unchanged.
- Force 65540 underruns (or preload): underrun_cnt saturates at 16'hFFFF; async reset clears it and all outputs immediately, without waiting for clk.
- I2S_TX_LJ_EN defined, word 32'h8001_0001: lrck rises with load; dacdat=1 in the first BCLK period of the left slot; left LSB at period 15; right LSB at period 47.
